// File: rtl/i2c_master_arbiter_if.sv
// Bundles the requester-side and I2CMaster-side signals of the arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic's view.
interface i2c_master_arbiter_if #(
    parameter int REQUESTER_COUNT = 2,
    parameter int INDEX_WIDTH     = (REQUESTER_COUNT > 1) ? $clog2(REQUESTER_COUNT) : 1
);
    logic [REQUESTER_COUNT-1:0]   req_ready;
    logic [7*REQUESTER_COUNT-1:0] req_address;
    logic [REQUESTER_COUNT-1:0]   req_rw;
    logic [8*REQUESTER_COUNT-1:0] req_register;
    logic [8*REQUESTER_COUNT-1:0] req_data_write;
    logic [REQUESTER_COUNT-1:0]   req_valid;
    logic                         req_nack;
    logic [7:0]                   req_data_read;
    logic                         master_ready;
    logic [6:0]                   master_address;
    logic                         master_rw;
    logic [7:0]                   master_register;
    logic [7:0]                   master_data_write;
    logic                         master_valid;
    logic                         master_nack;
    logic [7:0]                   master_data_read;
    logic [INDEX_WIDTH-1:0]       grant_index;
    logic                         busy;

    modport master (
        input  req_ready, req_address, req_rw, req_register, req_data_write,
               master_valid, master_nack, master_data_read,
        output req_valid, req_nack, req_data_read,
               master_ready, master_address, master_rw, master_register, master_data_write,
               grant_index, busy
    );

    modport slave (
        output req_ready, req_address, req_rw, req_register, req_data_write,
               master_valid, master_nack, master_data_read,
        input  req_valid, req_nack, req_data_read,
               master_ready, master_address, master_rw, master_register, master_data_write,
               grant_index, busy
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin share of one I2CMaster command port; grant 1 cycle after req_ready seen in IDLE,
// completion pulse 1 cycle after master_valid. One transaction at a time; others wait holding req_ready.
module i2c_master_arbiter #(
    parameter int REQUESTER_COUNT = 2,
    parameter int INDEX_WIDTH     = (REQUESTER_COUNT > 1) ? $clog2(REQUESTER_COUNT) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    i2c_master_arbiter_if.master  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state_q, state_d;
    logic [INDEX_WIDTH-1:0]     grant_q, grant_d;
    logic                       master_ready_q, master_ready_d;
    logic [6:0]                 address_q, address_d;
    logic                       rw_q, rw_d;
    logic [7:0]                 register_q, register_d;
    logic [7:0]                 data_write_q, data_write_d;
    logic [REQUESTER_COUNT-1:0] req_valid_q, req_valid_d;
    logic                       req_nack_q, req_nack_d;
    logic [7:0]                 req_data_read_q, req_data_read_d;
    logic                       busy_q, busy_d;

    logic win_found;
    int   win_idx;

    // Search starts just past the last grant, so the previous winner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        for (int k = 1; k <= REQUESTER_COUNT; k++) begin
            int idx;
            idx = (int'(grant_q) + k) % REQUESTER_COUNT;
            if (!win_found && bus.req_ready[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        master_ready_d  = master_ready_q;
        address_d       = address_q;
        rw_d            = rw_q;
        register_d      = register_q;
        data_write_d    = data_write_q;
        req_valid_d     = '0;
        req_nack_d      = req_nack_q;
        req_data_read_d = req_data_read_q;
        busy_d          = busy_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d        = INDEX_WIDTH'(win_idx);
                    address_d      = bus.req_address[7*win_idx +: 7];
                    rw_d           = bus.req_rw[win_idx];
                    register_d     = bus.req_register[8*win_idx +: 8];
                    data_write_d   = bus.req_data_write[8*win_idx +: 8];
                    master_ready_d = 1'b1;
                    busy_d         = 1'b1;
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                if (bus.master_valid) begin
                    req_valid_d[grant_q] = 1'b1;
                    req_nack_d           = bus.master_nack;
                    req_data_read_d      = bus.master_data_read;
                    master_ready_d       = 1'b0;
                    busy_d               = 1'b0;
                    state_d              = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            grant_q         <= INDEX_WIDTH'(REQUESTER_COUNT - 1);
            master_ready_q  <= 1'b0;
            address_q       <= '0;
            rw_q            <= 1'b0;
            register_q      <= '0;
            data_write_q    <= '0;
            req_valid_q     <= '0;
            req_nack_q      <= 1'b0;
            req_data_read_q <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            master_ready_q  <= master_ready_d;
            address_q       <= address_d;
            rw_q            <= rw_d;
            register_q      <= register_d;
            data_write_q    <= data_write_d;
            req_valid_q     <= req_valid_d;
            req_nack_q      <= req_nack_d;
            req_data_read_q <= req_data_read_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.master_ready      = master_ready_q;
    assign bus.master_address    = address_q;
    assign bus.master_rw         = rw_q;
    assign bus.master_register   = register_q;
    assign bus.master_data_write = data_write_q;
    assign bus.req_valid         = req_valid_q;
    assign bus.req_nack          = req_nack_q;
    assign bus.req_data_read     = req_data_read_q;
    assign bus.grant_index       = grant_q;
    assign bus.busy              = busy_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench: a 2-requester and a 3-requester arbiter sharing clock and reset.
module tb_i2c_master_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   seen;

    always #5 clock = ~clock;

    i2c_master_arbiter_if #(.REQUESTER_COUNT(2)) ifa ();
    i2c_master_arbiter_if #(.REQUESTER_COUNT(3)) ifb ();

    i2c_master_arbiter #(.REQUESTER_COUNT(2)) dut_a (.clock(clock), .reset(reset), .bus(ifa.master));
    i2c_master_arbiter #(.REQUESTER_COUNT(3)) dut_b (.clock(clock), .reset(reset), .bus(ifb.master));

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        ifa.req_ready = '0; ifa.req_address = '0; ifa.req_rw = '0;
        ifa.req_register = '0; ifa.req_data_write = '0;
        ifa.master_valid = 1'b0; ifa.master_nack = 1'b0; ifa.master_data_read = '0;
        ifb.req_ready = '0; ifb.req_address = '0; ifb.req_rw = '0;
        ifb.req_register = '0; ifb.req_data_write = '0;
        ifb.master_valid = 1'b0; ifb.master_nack = 1'b0; ifb.master_data_read = '0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_a_master_ready", 32'(ifa.master_ready), 32'd0);
        chk("rst_a_busy",         32'(ifa.busy),         32'd0);
        chk("rst_a_grant",        32'(ifa.grant_index),  32'd1);
        chk("rst_a_req_valid",    32'(ifa.req_valid),    32'd0);
        chk("rst_b_grant",        32'(ifb.grant_index),  32'd2);
        chk("rst_b_master_ready", 32'(ifb.master_ready), 32'd0);

        // N=2 single write from requester 0, completion after 50 cycles
        ifa.req_ready = 2'b01;
        ifa.req_address[6:0] = 7'h5E; ifa.req_rw[0] = 1'b0;
        ifa.req_register[7:0] = 8'h0A; ifa.req_data_write[7:0] = 8'h0C;
        step();
        chk("w_master_ready", 32'(ifa.master_ready),      32'd1);
        chk("w_busy",         32'(ifa.busy),              32'd1);
        chk("w_grant",        32'(ifa.grant_index),       32'd0);
        chk("w_address",      32'(ifa.master_address),    32'h5E);
        chk("w_rw",           32'(ifa.master_rw),         32'd0);
        chk("w_register",     32'(ifa.master_register),   32'h0A);
        chk("w_data_write",   32'(ifa.master_data_write), 32'h0C);
        ifa.req_ready = 2'b00;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (ifa.req_valid != 2'b00 || ifa.master_ready != 1'b1) seen++;
        end
        chk("w_wait_stable", 32'(seen), 32'd0);
        ifa.master_valid = 1'b1; ifa.master_nack = 1'b0;
        step();
        ifa.master_valid = 1'b0;
        chk("w_req_valid",     32'(ifa.req_valid),    32'b01);
        chk("w_req_nack",      32'(ifa.req_nack),     32'd0);
        chk("w_master_ready0", 32'(ifa.master_ready), 32'd0);
        chk("w_busy0",         32'(ifa.busy),         32'd0);
        step();
        chk("w_pulse_end",     32'(ifa.req_valid),    32'b00);

        // N=3, all requesters pending: strict rotation 0,1,2,0,1,2
        for (int i = 0; i < 3; i++) begin
            ifb.req_address[7*i +: 7]  = 7'(8'h10 + i);
            ifb.req_register[8*i +: 8] = 8'(8'h20 + i);
        end
        ifb.req_ready = 3'b111;
        for (int t = 0; t < 6; t++) begin
            step();
            chk("rr_master_ready", 32'(ifb.master_ready),   32'd1);
            chk("rr_grant",        32'(ifb.grant_index),    32'(t % 3));
            chk("rr_address",      32'(ifb.master_address), 32'(8'h10 + (t % 3)));
            ifb.master_valid = 1'b1;
            step();
            ifb.master_valid = 1'b0;
            chk("rr_req_valid",    32'(ifb.req_valid),      32'(1 << (t % 3)));
            chk("rr_idle_gap",     32'(ifb.master_ready),   32'd0);
        end
        ifb.req_ready = 3'b000;
        step();

        // Requester 1 read: ack with data, then nack
        ifb.req_address[13:7] = 7'h54; ifb.req_rw = 3'b010; ifb.req_register[15:8] = 8'h21;
        ifb.req_ready = 3'b010;
        step();
        chk("rd_grant",    32'(ifb.grant_index),     32'd1);
        chk("rd_address",  32'(ifb.master_address),  32'h54);
        chk("rd_rw",       32'(ifb.master_rw),       32'd1);
        chk("rd_register", 32'(ifb.master_register), 32'h21);
        ifb.master_valid = 1'b1; ifb.master_nack = 1'b0; ifb.master_data_read = 8'hA5;
        step();
        ifb.master_valid = 1'b0;
        chk("rd_req_valid", 32'(ifb.req_valid),     32'b010);
        chk("rd_data",      32'(ifb.req_data_read), 32'hA5);
        chk("rd_nack",      32'(ifb.req_nack),      32'd0);
        step();
        chk("rd2_master_ready", 32'(ifb.master_ready), 32'd1);
        chk("rd2_grant",        32'(ifb.grant_index),  32'd1);
        ifb.req_ready = 3'b000;
        ifb.master_valid = 1'b1; ifb.master_nack = 1'b1; ifb.master_data_read = 8'h3C;
        step();
        ifb.master_valid = 1'b0; ifb.master_nack = 1'b0;
        chk("nk_req_valid", 32'(ifb.req_valid),       32'b010);
        chk("nk_nack",      32'(ifb.req_nack),        32'd1);
        chk("nk_data",      32'(ifb.req_data_read),   32'h3C);
        chk("nk_address",   32'(ifb.master_address),  32'h54);
        chk("nk_register",  32'(ifb.master_register), 32'h21);

        // Command fields frozen while busy
        ifb.req_rw = 3'b000; ifb.req_register[7:0] = 8'h20;
        ifb.req_ready = 3'b001;
        step();
        chk("fz_grant",    32'(ifb.grant_index),     32'd0);
        chk("fz_register", 32'(ifb.master_register), 32'h20);
        ifb.req_register[7:0] = 8'h30;
        ifb.req_ready = 3'b000;
        step(); step(); step();
        chk("fz_register_held", 32'(ifb.master_register), 32'h20);
        chk("fz_busy",          32'(ifb.busy),            32'd1);
        ifb.master_valid = 1'b1;
        step();
        ifb.master_valid = 1'b0;
        chk("fz_req_valid", 32'(ifb.req_valid), 32'b001);
        step();

        // Reset while busy, then stray completion in IDLE
        ifb.req_ready = 3'b100;
        step();
        chk("rb_grant",        32'(ifb.grant_index),  32'd2);
        chk("rb_master_ready", 32'(ifb.master_ready), 32'd1);
        ifb.req_ready = 3'b000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rb_master_ready0", 32'(ifb.master_ready), 32'd0);
        chk("rb_busy0",         32'(ifb.busy),         32'd0);
        chk("rb_req_valid",     32'(ifb.req_valid),    32'd0);
        chk("rb_grant_rst",     32'(ifb.grant_index),  32'd2);
        ifb.master_valid = 1'b1;
        step();
        ifb.master_valid = 1'b0;
        chk("stray_req_valid", 32'(ifb.req_valid), 32'd0);
        step();
        chk("stray_req_valid2", 32'(ifb.req_valid), 32'd0);
        chk("stray_busy",       32'(ifb.busy),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
